// File: rtl/pe_pkg.sv
// Shared definitions for the PE operand join stage: default operand width,
// the operand mask type and the mask bit index for each operand channel.
package pe_pkg;

    // Default operand width, matching the PE ALU data ports.
    localparam int PE_DATA_WIDTH = 32;

    // Number of operand channels feeding the ALU.
    localparam int PE_NUM_OPS = 3;

    // Bit positions of each operand inside the operand mask.
    localparam int PE_OP1 = 0;
    localparam int PE_OP2 = 1;
    localparam int PE_OP3 = 2;

    // Bit i set means operand i+1 is needed by the configured ALU function.
    typedef logic [PE_NUM_OPS-1:0] pe_operand_mask_t;

    // A mask with no bits set parks the stage: nothing is ever issued.
    function automatic logic pe_mask_active(input pe_operand_mask_t mask);
        return (mask != 3'b000);
    endfunction

endpackage

// File: rtl/pe_operand_slot.sv
// One operand hold register with its valid/ready handshake.
// A channel that is not required is always ready, discards its payload and
// never reports itself as holding an operand.
module pe_operand_slot
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  required,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  fire,
    output logic                  in_ready,
    output logic                  held,
    output logic [DATA_WIDTH-1:0] hold_data
);

    logic                  held_r;
    logic [DATA_WIDTH-1:0] hold_data_r;
    logic                  in_ready_s;
    logic                  xfer_s;

    // Ready when empty or when the held operand leaves this cycle; a transfer
    // only counts for a required channel.
    always_comb begin
        in_ready_s = 1'b1;
        xfer_s     = 1'b0;
        if (required) begin
            in_ready_s = !held_r || fire;
            xfer_s     = in_valid && in_ready_s;
        end else begin
            in_ready_s = 1'b1;
            xfer_s     = 1'b0;
        end
    end

    // Occupancy flag: a new transfer wins over consumption by the issue stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_r <= 1'b0;
        end else if (!required) begin
            held_r <= 1'b0;
        end else if (xfer_s) begin
            held_r <= 1'b1;
        end else if (fire) begin
            held_r <= 1'b0;
        end else begin
            held_r <= held_r;
        end
    end

    // Payload capture on every accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_r <= {DATA_WIDTH{1'b0}};
        end else if (xfer_s) begin
            hold_data_r <= in_data;
        end else begin
            hold_data_r <= hold_data_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign held      = held_r;
    assign hold_data = hold_data_r;

endmodule

// File: rtl/pe_operand_join.sv
// Operand join and issue stage in front of the PE ALU.
// Collects up to three operands from independent valid/ready streams, issues
// them together as one registered bundle and counts issued bundles.
// Optional feature macro: PE_CONST_OPERAND_EN adds const_data/const_sel so
// operand 3 can come from a constant instead of channel 3.
module pe_operand_join
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  pe_operand_mask_t           operand_mask,
    input  logic [3:1][DATA_WIDTH-1:0] in_data,
    input  logic [3:1]                 in_valid,
    output logic [3:1]                 in_ready,
    output logic [DATA_WIDTH-1:0]      data_in1,
    output logic [DATA_WIDTH-1:0]      data_in2,
    output logic [DATA_WIDTH-1:0]      data_in3,
    output logic                       issue_valid,
    input  logic                       issue_ready,
`ifdef PE_CONST_OPERAND_EN
    input  logic [DATA_WIDTH-1:0]      const_data,
    input  logic                       const_sel,
`endif
    output logic [CNT_WIDTH-1:0]       issue_count
);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (&value) begin
            return value;
        end else begin
            return value + CNT_WIDTH'(1);
        end
    endfunction

    logic [3:1]                 slot_req_s;
    logic [3:1]                 held_s;
    logic [3:1][DATA_WIDTH-1:0] hold_data_s;
    logic [3:1]                 present_s;
    logic                       all_present_s;
    logic                       out_free_s;
    logic                       fire_s;
    logic [DATA_WIDTH-1:0]      op3_s;

    logic                       issue_valid_r;
    logic [DATA_WIDTH-1:0]      data_in1_r;
    logic [DATA_WIDTH-1:0]      data_in2_r;
    logic [DATA_WIDTH-1:0]      data_in3_r;
    logic [CNT_WIDTH-1:0]       issue_count_r;

    // Which channels actually hold operands; a constant operand 3 makes
    // channel 3 behave like an unmasked, always-ready channel.
    always_comb begin
        slot_req_s = {operand_mask[PE_OP3], operand_mask[PE_OP2], operand_mask[PE_OP1]};
        op3_s      = hold_data_s[3];
`ifdef PE_CONST_OPERAND_EN
        if (const_sel) begin
            slot_req_s[3] = 1'b0;
            op3_s         = const_data;
        end else begin
            slot_req_s[3] = operand_mask[PE_OP3];
            op3_s         = hold_data_s[3];
        end
`endif
    end

    // Join condition: every needed operand present and the output register
    // either empty or being drained this cycle.
    always_comb begin
        present_s     = held_s | ~slot_req_s;
        all_present_s = &present_s;
        out_free_s    = !issue_valid_r || issue_ready;
        fire_s        = all_present_s && out_free_s && pe_mask_active(operand_mask);
    end

    // One hold slot per operand channel.
    for (genvar ch = 1; ch <= 3; ch++) begin : g_slot
        pe_operand_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk       (CLK),
            .rst       (RESET),
            .required  (slot_req_s[ch]),
            .in_valid  (in_valid[ch]),
            .in_data   (in_data[ch]),
            .fire      (fire_s),
            .in_ready  (in_ready[ch]),
            .held      (held_s[ch]),
            .hold_data (hold_data_s[ch])
        );
    end

    // Issue valid flag: set on fire, cleared when the bundle is taken and
    // nothing new replaces it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            issue_valid_r <= 1'b0;
        end else if (fire_s) begin
            issue_valid_r <= 1'b1;
        end else if (issue_ready) begin
            issue_valid_r <= 1'b0;
        end else begin
            issue_valid_r <= issue_valid_r;
        end
    end

    // Issued operand registers: only operands the mask needs are updated, the
    // others keep whatever was last issued.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_in1_r <= {DATA_WIDTH{1'b0}};
            data_in2_r <= {DATA_WIDTH{1'b0}};
            data_in3_r <= {DATA_WIDTH{1'b0}};
        end else if (fire_s) begin
            if (operand_mask[PE_OP1]) begin
                data_in1_r <= hold_data_s[1];
            end else begin
                data_in1_r <= data_in1_r;
            end
            if (operand_mask[PE_OP2]) begin
                data_in2_r <= hold_data_s[2];
            end else begin
                data_in2_r <= data_in2_r;
            end
            if (operand_mask[PE_OP3]) begin
                data_in3_r <= op3_s;
            end else begin
                data_in3_r <= data_in3_r;
            end
        end else begin
            data_in1_r <= data_in1_r;
            data_in2_r <= data_in2_r;
            data_in3_r <= data_in3_r;
        end
    end

    // Debug counter of issued bundles, saturating at all-ones.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            issue_count_r <= {CNT_WIDTH{1'b0}};
        end else if (fire_s) begin
            issue_count_r <= sat_inc(issue_count_r);
        end else begin
            issue_count_r <= issue_count_r;
        end
    end

    assign issue_valid = issue_valid_r;
    assign data_in1    = data_in1_r;
    assign data_in2    = data_in2_r;
    assign data_in3    = data_in3_r;
    assign issue_count = issue_count_r;

endmodule

// File: tb/tb_pe_operand_join.sv
// Self-checking bench for pe_operand_join: per-channel operand queues drive the
// inputs, expected bundles go to a scoreboard queue when stimulus is queued and
// are compared whenever the DUT hands a bundle to the ALU side.
module tb_pe_operand_join;
    import pe_pkg::*;

    localparam int DW = 32;
    localparam int CW = 16;

    logic                CLK = 1'b0;
    logic                RESET;
    pe_operand_mask_t    operand_mask;
    logic [3:1][DW-1:0]  in_data;
    logic [3:1]          in_valid;
    logic [3:1]          in_ready;
    logic [DW-1:0]       data_in1;
    logic [DW-1:0]       data_in2;
    logic [DW-1:0]       data_in3;
    logic                issue_valid;
    logic                issue_ready;
    logic [CW-1:0]       issue_count;
`ifdef PE_CONST_OPERAND_EN
    logic [DW-1:0]       const_data;
    logic                const_sel;
`endif

    typedef struct packed {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] d3;
    } bundle_t;

    bundle_t       exp_q[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic [DW-1:0] q3[$];
    logic [3:1]    gate;
    bundle_t       last_b;
    int            n_pushed;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 CLK = ~CLK;

    pe_operand_join #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .operand_mask (operand_mask),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in1     (data_in1),
        .data_in2     (data_in2),
        .data_in3     (data_in3),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
`ifdef PE_CONST_OPERAND_EN
        .const_data   (const_data),
        .const_sel    (const_sel),
`endif
        .issue_count  (issue_count)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Queue operands for the masked channels and the bundle they must form.
    task automatic push_bundle(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [DW-1:0] c, input logic [2:0] m,
                               input logic c_const);
        bundle_t e;
        e = last_b;
        if (m[0]) begin q1.push_back(a); e.d1 = a; end
        if (m[1]) begin q2.push_back(b); e.d2 = b; end
        if (m[2]) begin
            if (!c_const) q3.push_back(c);
            e.d3 = c;
        end
        exp_q.push_back(e);
        last_b = e;
        n_pushed++;
    endtask

    task automatic drive();
        in_valid[1] = gate[1] && (q1.size() > 0);
        in_valid[2] = gate[2] && (q2.size() > 0);
        in_valid[3] = gate[3] && (q3.size() > 0);
        in_data[1]  = (q1.size() > 0) ? q1[0] : '0;
        in_data[2]  = (q2.size() > 0) ? q2[0] : '0;
        in_data[3]  = (q3.size() > 0) ? q3[0] : '0;
    endtask

    // One clock: drive at the falling edge, sample handshakes just before the
    // rising edge, return at the next falling edge.
    task automatic step();
        logic [3:1] acc;
        logic       oacc;
        bundle_t    e;
        drive();
        #4;
        acc  = in_valid & in_ready;
        oacc = issue_valid & issue_ready;
        if (oacc) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data_in1", 64'(data_in1), 64'(e.d1));
                check("sb_data_in2", 64'(data_in2), 64'(e.d2));
                check("sb_data_in3", 64'(data_in3), 64'(e.d3));
            end
        end
        if (acc[1]) void'(q1.pop_front());
        if (acc[2]) void'(q2.pop_front());
        if (acc[3]) void'(q3.pop_front());
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int k;
        k = 0;
        while ((exp_q.size() > 0 || issue_valid) && k < max_cycles) begin
            step();
            k++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ra, rb, rc;
        bundle_t bA, bB;
        int vcnt, rises, k;
        logic prev;

        RESET        = 1'b1;
        operand_mask = 3'b000;
        gate         = 3'b000;
        in_valid     = 3'b000;
        in_data      = '0;
        issue_ready  = 1'b1;
        last_b       = '0;
        n_pushed     = 0;
`ifdef PE_CONST_OPERAND_EN
        const_data   = '0;
        const_sel    = 1'b0;
`endif
        #2;
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_issue_count", 64'(issue_count), 64'd0);
        check("rst_data_in1", 64'(data_in1), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd7);
        @(negedge CLK);
        step();
        RESET = 1'b0;
        step();

        // Two-operand join, latency and single-cycle pulse.
        operand_mask = 3'b011;
        push_bundle(32'h5, 32'h7, 32'h0, 3'b011, 1'b0);
        step();
        gate = 3'b001;
        step();
        step();
        step();
        gate = 3'b011;
        step();
        check("t1_no_issue_at_capture", 64'(issue_valid), 64'd0);
        step();
        check("t1_issue_valid", 64'(issue_valid), 64'd1);
        check("t1_data_in1", 64'(data_in1), 64'h5);
        check("t1_data_in2", 64'(data_in2), 64'h7);
        check("t1_issue_count", 64'(issue_count), 64'd1);
        step();
        check("t1_pulse_end", 64'(issue_valid), 64'd0);
        drain("t1", 10);

        // Eight back-to-back bundles on all three channels.
        operand_mask = 3'b111;
        gate = 3'b111;
        for (int i = 0; i < 8; i++) begin
            push_bundle($urandom, $urandom, $urandom, 3'b111, 1'b0);
        end
        vcnt = 0;
        rises = 0;
        prev = issue_valid;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i < 8) check("t2_in_ready", 64'(in_ready), 64'd7);
            if (issue_valid) vcnt++;
            if (issue_valid && !prev) rises++;
            prev = issue_valid;
        end
        check("t2_valid_cycles", 64'(vcnt), 64'd8);
        check("t2_valid_runs", 64'(rises), 64'd1);
        drain("t2", 10);
        check("t2_issue_count", 64'(issue_count), 64'(n_pushed));

        // Back-pressure: first bundle held, second captured, channels stall.
        issue_ready = 1'b0;
        ra = $urandom; rb = $urandom; rc = $urandom;
        push_bundle(ra, rb, rc, 3'b111, 1'b0);
        bA = last_b;
        ra = $urandom; rb = $urandom; rc = $urandom;
        push_bundle(ra, rb, rc, 3'b111, 1'b0);
        bB = last_b;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check("t3_stall_in_ready", 64'(in_ready), 64'd0);
            check("t3_stall_valid", 64'(issue_valid), 64'd1);
            check("t3_stall_data_in1", 64'(data_in1), 64'(bA.d1));
            check("t3_stall_data_in3", 64'(data_in3), 64'(bA.d3));
            step();
        end
        issue_ready = 1'b1;
        step();
        check("t3_second_valid", 64'(issue_valid), 64'd1);
        check("t3_second_data_in1", 64'(data_in1), 64'(bB.d1));
        drain("t3", 10);
        check("t3_issue_count", 64'(issue_count), 64'(n_pushed));

        // Mask 101: channel 2 always ready, its payload never issued.
        operand_mask = 3'b101;
        for (int i = 0; i < 4; i++) begin
            push_bundle($urandom, $urandom, $urandom, 3'b101, 1'b0);
        end
        for (int i = 0; i < 20; i++) q2.push_back($urandom);
        k = 0;
        while ((exp_q.size() > 0 || issue_valid) && k < 20) begin
            step();
            check("t4_in_ready2", 64'(in_ready[2]), 64'd1);
            k++;
        end
        check("t4_drained", 64'(exp_q.size()), 64'd0);
        q2.delete();
        check("t4_issue_count", 64'(issue_count), 64'(n_pushed));

        // Reset while a bundle is valid and an operand is held.
        operand_mask = 3'b011;
        issue_ready = 1'b0;
        gate = 3'b011;
        push_bundle($urandom, $urandom, 32'h0, 3'b011, 1'b0);
        q1.push_back($urandom);
        step();
        step();
        check("t5_pre_valid", 64'(issue_valid), 64'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("t5_rst_valid", 64'(issue_valid), 64'd0);
        check("t5_rst_count", 64'(issue_count), 64'd0);
        check("t5_rst_data_in1", 64'(data_in1), 64'd0);
        q1.delete(); q2.delete(); q3.delete(); exp_q.delete();
        last_b = '0;
        n_pushed = 0;
        @(negedge CLK);
        RESET = 1'b0;
        issue_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_no_spurious", 64'(issue_valid), 64'd0);
        end
        check("t5_count_after", 64'(issue_count), 64'd0);

`ifdef PE_CONST_OPERAND_EN
        // Constant operand 3: only channels 1 and 2 carry data.
        const_sel = 1'b1;
        const_data = 32'h1234;
        operand_mask = 3'b111;
        gate = 3'b011;
        push_bundle($urandom, $urandom, 32'h1234, 3'b111, 1'b1);
        drain("t6a", 10);
        check("t6_in_ready3", 64'(in_ready[3]), 64'd1);
        push_bundle($urandom, $urandom, 32'h1234, 3'b111, 1'b1);
        drain("t6b", 10);
        check("t6_data_in3", 64'(data_in3), 64'h1234);
        check("t6_issue_count", 64'(issue_count), 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
